sample_fifo_apb_reader: RTL and testbench

APB-slave drain engine for the sensor sample FIFO: the read end of the path whose write end is the RTC-triggered ADC sampling controller. It prefetches one word from the FIFO into a holding register and serves it through a zero-wait APB DATA register. It also keeps status, error and sample-count information and raises a level interrupt when a new sample is available.

---
 rtl/sample_fifo_apb_reader_if.sv | 37 +++
 rtl/sample_fifo_apb_reader.sv | 154 +++++++++++++++
 tb/tb_sample_fifo_apb_reader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sample_fifo_apb_reader_if.sv
// APB3 slave-side bus bundle for the sample FIFO reader.
//   psel/penable/pwrite/paddr/pwdata : requester -> completer
//   prdata/pready/pslverr            : completer -> requester
// The 'slave' modport is used by the reader. The 'master' modport is used by a bus
// requester or a testbench.
interface sample_fifo_apb_reader_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport slave (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output prdata,
        output pready,
        output pslverr
    );

    modport master (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  prdata,
        input  pready,
        input  pslverr
    );
endinterface

// File: rtl/sample_fifo_apb_reader.sv
// Drain engine for the sensor sample FIFO. It prefetches one word into a holding
// register and serves that word through a zero-wait APB DATA register. It also
// keeps status bits, sticky error bits and a read counter.
//   clk, rst        : system clock; asynchronous active-high reset
//   apb             : APB slave bus (DATA 0x0, STATUS 0x4, CTRL 0x8, 0xC unmapped)
//   fifo_empty      : sample FIFO is empty
//   fifo_rd_en      : one-cycle pop strobe; data arrives on fifo_rd_data next cycle
//   fifo_rd_data    : FIFO output word
//   apb_fifo_ready  : overflow indication from the sampling controller
//   irq             : level interrupt, irq_en & pending
module sample_fifo_apb_reader #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    sample_fifo_apb_reader_if.slave  apb,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic [DATA_W-1:0]        fifo_rd_data,
    input  logic                     apb_fifo_ready,
    output logic                     irq
);

    typedef enum logic [1:0] {StEmpty, StFetch, StFull} state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   hold_q;
    logic                hold_valid_q;
    logic                en_q;
    logic                irq_en_q;
    logic                underflow_q;
    logic                pending_q;
    logic                overflow_q;
    logic [15:0]         read_count_q;

    logic        access;
    logic        rd_acc;
    logic        wr_acc;
    logic        sel_data;
    logic        sel_status;
    logic        sel_ctrl;
    logic        sel_unmapped;
    logic        data_ok;
    logic        data_under;
    logic        status_wr;
    logic        ctrl_wr;
    logic        pop;
    logic [31:0] hold_ext;
    logic [31:0] status_word;
    logic        unused_bits;

    // Address decode. Side effects happen only in the access phase.
    assign access       = apb.psel & apb.penable;
    assign rd_acc       = access & ~apb.pwrite;
    assign wr_acc       = access & apb.pwrite;
    assign sel_data     = (apb.paddr[3:2] == 2'd0);
    assign sel_status   = (apb.paddr[3:2] == 2'd1);
    assign sel_ctrl     = (apb.paddr[3:2] == 2'd2);
    assign sel_unmapped = (apb.paddr[3:2] == 2'd3);

    assign data_ok    = rd_acc & sel_data & (state_q == StFull);
    assign data_under = rd_acc & sel_data & (state_q != StFull);
    assign status_wr  = wr_acc & sel_status;
    assign ctrl_wr    = wr_acc & sel_ctrl;

    // A pop happens from EMPTY, or from FULL in the same cycle that the held word is
    // read. That second case lets a back-to-back read find a fresh word.
    assign pop        = en_q & ~fifo_empty & ((state_q == StEmpty) | data_ok);
    assign fifo_rd_en = pop;

    assign irq    = irq_en_q & pending_q;
    assign apb.pready = 1'b1;

    always_comb begin
        hold_ext = '0;
        hold_ext[DATA_W-1:0] = hold_q;
    end

    assign status_word = {read_count_q, 11'd0, overflow_q, pending_q, underflow_q,
                          fifo_empty, hold_valid_q};

    always_comb begin
        apb.prdata = '0;
        if (rd_acc) begin
            if (data_ok) begin
                apb.prdata = hold_ext;
            end else if (sel_status) begin
                apb.prdata = status_word;
            end else if (sel_ctrl) begin
                apb.prdata = {30'd0, irq_en_q, en_q};
            end
        end
    end

    assign apb.pslverr = access & (sel_unmapped | data_under);

    // Prefetch FSM and holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StEmpty;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (pop) begin
                        state_q <= StFetch;
                    end
                end
                // This state completes even if en has dropped, because the word has
                // already left the FIFO.
                StFetch: begin
                    hold_q       <= fifo_rd_data;
                    hold_valid_q <= 1'b1;
                    state_q      <= StFull;
                end
                StFull: begin
                    if (data_ok) begin
                        hold_valid_q <= 1'b0;
                        state_q      <= pop ? StFetch : StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    // Control and status registers. On the sticky bits, a hardware set wins over
    // a W1C write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q         <= 1'b0;
            irq_en_q     <= 1'b0;
            underflow_q  <= 1'b0;
            pending_q    <= 1'b0;
            overflow_q   <= 1'b0;
            read_count_q <= '0;
        end else begin
            if (ctrl_wr) begin
                en_q     <= apb.pwdata[0];
                irq_en_q <= apb.pwdata[1];
            end
            underflow_q <= data_under | (underflow_q & ~(status_wr & apb.pwdata[2]));
            pending_q   <= (state_q == StFetch) | (pending_q & ~(status_wr & apb.pwdata[3]));
            overflow_q  <= apb_fifo_ready | (overflow_q & ~(status_wr & apb.pwdata[4]));
            if (data_ok) begin
                read_count_q <= read_count_q + 16'd1;
            end
        end
    end

    assign unused_bits = ^{apb.pwdata[31:5], apb.paddr[1:0]};

endmodule

// File: tb/tb_sample_fifo_apb_reader.sv
module tb_sample_fifo_apb_reader;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data;
    logic        apb_fifo_ready;
    logic        irq;

    sample_fifo_apb_reader_if bus();

    sample_fifo_apb_reader #(.DATA_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .apb            (bus),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_rd_data   (fifo_rd_data),
        .apb_fifo_ready (apb_fifo_ready),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample FIFO model: the bench pushes into mem, and a pop registers the word.
    logic [15:0] mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops   = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr[4:0]];
            rd_ptr       <= rd_ptr + 1;
            pops         <= pops + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        mem[wr_ptr[4:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = a;   bus.pwdata = d;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        d   = bus.prdata;
        err = bus.pslverr;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] rd;
    logic        err;
    int          snap;
    logic        seen;

    initial begin
        rst = 1'b1;
        apb_fifo_ready = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0;  bus.pwdata = '0;
        idle(2);
        check("rst_rd_en",   {31'd0, fifo_rd_en},  32'd0);
        check("rst_irq",     {31'd0, irq},         32'd0);
        check("rst_prdata",  bus.prdata,           32'd0);
        check("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
        check("rst_pready",  {31'd0, bus.pready},  32'd1);
        rst = 1'b0;
        idle(1);

        // Single word prefetch, then irq and DATA read.
        push(16'h00A5);
        apb_write(4'h8, 32'h3);
        idle(4);
        check("t1_pops", pops, 32'd1);
        apb_read(4'h4, rd, err);
        check("t1_status", rd & ~32'h2, 32'h0000_0009);
        check("t1_status_empty", {31'd0, rd[1]}, 32'd1);
        check("t1_irq", {31'd0, irq}, 32'd1);
        apb_read(4'h0, rd, err);
        check("t1_data", rd, 32'h0000_00A5);
        check("t1_data_err", {31'd0, err}, 32'd0);
        apb_read(4'h4, rd, err);
        check("t1_count", {16'd0, rd[31:16]}, 32'd1);
        check("t1_hold_valid", {31'd0, rd[0]}, 32'd0);

        // Underflow with en=0 and an empty FIFO, then clear it with W1C.
        apb_write(4'h8, 32'h0);
        check("t2_irq_off", {31'd0, irq}, 32'd0);
        apb_read(4'h0, rd, err);
        check("t2_under_err", {31'd0, err}, 32'd1);
        check("t2_under_data", rd, 32'd0);
        apb_read(4'h4, rd, err);
        check("t2_under_bit", {31'd0, rd[2]}, 32'd1);
        apb_write(4'h4, 32'h4);
        apb_read(4'h4, rd, err);
        check("t2_under_clr", {31'd0, rd[2]}, 32'd0);
        apb_read(4'hC, rd, err);
        check("t2_unmap_err", {31'd0, err}, 32'd1);
        check("t2_unmap_data", rd, 32'd0);

        // Four back-to-back DATA reads from a preloaded FIFO.
        for (int i = 1; i <= 4; i++) push(16'(i));
        snap = pops;
        apb_write(4'h8, 32'h1);
        idle(4);
        for (int i = 1; i <= 4; i++) begin
            apb_read(4'h0, rd, err);
            check($sformatf("t3_data%0d", i), rd, 32'(i));
            check($sformatf("t3_err%0d", i), {31'd0, err}, 32'd0);
        end
        idle(2);
        check("t3_pops", pops - snap, 32'd4);
        apb_read(4'h4, rd, err);
        check("t3_count", {16'd0, rd[31:16]}, 32'd5);
        check("t3_hold_valid", {31'd0, rd[0]}, 32'd0);
        apb_read(4'h0, rd, err);
        check("t3_empty_err", {31'd0, err}, 32'd1);
        apb_write(4'h4, 32'h4);

        // Overflow sticky bit, and a set that wins over W1C in the same cycle.
        apb_fifo_ready = 1'b1;
        idle(1);
        apb_fifo_ready = 1'b0;
        apb_read(4'h4, rd, err);
        check("t4_ovf_set", {31'd0, rd[4]}, 32'd1);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 4'h4; bus.pwdata = 32'h10;
        idle(1);
        bus.penable = 1'b1;
        apb_fifo_ready = 1'b1;
        idle(1);
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        apb_fifo_ready = 1'b0;
        apb_read(4'h4, rd, err);
        check("t4_ovf_wins", {31'd0, rd[4]}, 32'd1);
        apb_write(4'h4, 32'h10);
        apb_read(4'h4, rd, err);
        check("t4_ovf_clr", {31'd0, rd[4]}, 32'd0);

        // read_count wrap. The counter is preset to 0xFFFF so that this test does not
        // need 64k real reads.
        force dut.read_count_q = 16'hFFFF;
        idle(1);
        release dut.read_count_q;
        idle(1);
        apb_read(4'h4, rd, err);
        check("t5_count_max", {16'd0, rd[31:16]}, 32'h0000_FFFF);
        push(16'h1234);
        idle(4);
        apb_read(4'h0, rd, err);
        check("t5_data", rd, 32'h0000_1234);
        apb_read(4'h4, rd, err);
        check("t5_count_wrap", {16'd0, rd[31:16]}, 32'd0);

        // Reset in the cycle after a pop (FSM in FETCH).
        push(16'h0BAD);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (fifo_rd_en) seen = 1'b1;
            else begin
                @(posedge clk);
            end
        end
        check("t6_pop_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t6_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        idle(1);
        rst = 1'b0;
        snap = pops;
        push(16'h0C0D);
        idle(5);
        check("t6_no_pop", pops, snap);
        apb_read(4'h4, rd, err);
        check("t6_status", rd, 32'd0);
        apb_read(4'h8, rd, err);
        check("t6_ctrl", rd, 32'd0);
        apb_write(4'h8, 32'h1);
        idle(4);
        check("t6_repop", pops, snap + 1);
        apb_read(4'h0, rd, err);
        check("t6_data", rd, 32'h0000_0C0D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
